pe_inj_ctrl: RTL and testbench

Injection controller for one processing element's 2-VC flit source memory.
- Issues rd_en to the PE flit memory; rd_en also serves as the request to the crossbar arbiter.
- Keeps packets atomic on a single VC and tracks downstream credits per VC.
- Inserts a configurable idle gap between packets and stops after a fixed packet count.
- Sits between the PE flit memory, the crossbar arbiter (grt) and the router input-buffer credit return.

---
 rtl/pe_inj_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pe_inj_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_inj_ctrl.sv
// pe_inj_ctrl: injection controller for one PE's 2-VC flit source memory.
//
// Issues rd_en to the flit memory (rd_en doubles as the crossbar arbiter
// request). A flit moves on any cycle with rd_en & grt. Packets stay atomic on
// one VC, downstream credits are tracked per VC, a programmable idle gap is
// inserted between packets, and the run stops after NUM_PKT packets.
//
// Ports:
//   clk        clock, rising edge
//   rst_       asynchronous reset, active-high
//   start      single-cycle pulse, starts a run from IDLE or DONE
//   gap_cfg    idle cycles between a tail flit and the next head flit
//   grt        grant from the crossbar arbiter
//   fifo_ovch  VC of the flit being read (meaningful when rd_en & grt)
//   cred_ret   per-VC credit return pulses (bit0 = VC0, bit1 = VC1)
//   rd_en      read request to flit memory / request to arbiter
//   busy       high in HEAD, BODY, GAP
//   done       high in DONE
//   pkt_cnt    packets completed in the current run
//   cred_err   sticky: credit returned to an already-full counter
module pe_inj_ctrl #(
    parameter int FLITS_PER_PKT = 4,
    parameter int NUM_PKT       = 64,
    parameter int CRED_DEPTH    = 4,
    parameter int CREDW         = 3,
    parameter int GAPW          = 4
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            start,
    input  logic [GAPW-1:0] gap_cfg,
    input  logic            grt,
    input  logic            fifo_ovch,
    input  logic [1:0]      cred_ret,
    output logic            rd_en,
    output logic            busy,
    output logic            done,
    output logic [6:0]      pkt_cnt,
    output logic            cred_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [CREDW-1:0] CRED_FULL = CREDW'(CRED_DEPTH);
    localparam logic [3:0]       TAIL_IDX  = 4'(FLITS_PER_PKT - 1);
    localparam logic [6:0]       LAST_PKT  = 7'(NUM_PKT - 1);

    state_t                  state, state_nxt;
    logic [1:0][CREDW-1:0]   cred;
    logic [3:0]              flit_cnt;
    logic                    cur_vc;
    logic [GAPW-1:0]         gap_cnt;

    logic                    xfer;
    logic                    xfer_vc;
    logic                    tail;
    logic [1:0]              dec;
    logic                    load_gap;
    logic                    clr_pkt;

    // rd_en depends only on state and credit registers, never on grt, so the
    // arbiter handshake has no combinational loop.
    always_comb begin
        rd_en = 1'b0;
        case (state)
            // Head's VC is unknown until read, so both VCs need credit.
            S_HEAD:  rd_en = (cred[0] != '0) && (cred[1] != '0);
            S_BODY:  rd_en = (cred[cur_vc] != '0);
            default: rd_en = 1'b0;
        endcase
    end

    assign busy    = (state == S_HEAD) || (state == S_BODY) || (state == S_GAP);
    assign done    = (state == S_DONE);
    assign xfer    = rd_en & grt;
    // Body flits always go on the VC latched at the head.
    assign xfer_vc = (state == S_HEAD) ? fifo_ovch : cur_vc;
    assign tail    = (state == S_BODY) && xfer && (flit_cnt == TAIL_IDX);
    assign dec[0]  = xfer & ~xfer_vc;
    assign dec[1]  = xfer &  xfer_vc;

    always_comb begin
        state_nxt = state;
        load_gap  = 1'b0;
        clr_pkt   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_HEAD;
                    clr_pkt   = 1'b1;
                end
            end
            S_HEAD: begin
                if (xfer) state_nxt = S_BODY;
            end
            S_BODY: begin
                if (tail) begin
                    if (pkt_cnt == LAST_PKT) begin
                        state_nxt = S_DONE;
                    end else if (gap_cfg == '0) begin
                        state_nxt = S_HEAD;
                    end else begin
                        state_nxt = S_GAP;
                        load_gap  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAPW'(1)) state_nxt = S_HEAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state    <= S_IDLE;
            flit_cnt <= '0;
            cur_vc   <= 1'b0;
            gap_cnt  <= '0;
            pkt_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_HEAD && xfer) begin
                cur_vc   <= fifo_ovch;
                flit_cnt <= 4'd1;
            end else if (state == S_BODY && xfer) begin
                flit_cnt <= flit_cnt + 4'd1;
            end
            if (load_gap) begin
                gap_cnt <= gap_cfg;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GAPW'(1);
            end
            if (clr_pkt) begin
                pkt_cnt <= '0;
            end else if (tail) begin
                pkt_cnt <= pkt_cnt + 7'd1;
            end
        end
    end

    // Credits update in every state. A use and a return on the same VC in
    // the same cycle cancel out; a return to a full counter is an error.
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            cred     <= {CRED_FULL, CRED_FULL};
            cred_err <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (dec[v] && !cred_ret[v]) begin
                    cred[v] <= cred[v] - CREDW'(1);
                end else if (cred_ret[v] && !dec[v]) begin
                    if (cred[v] == CRED_FULL) cred_err <= 1'b1;
                    else                      cred[v]  <= cred[v] + CREDW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_inj_ctrl.sv
module tb_pe_inj_ctrl;

    localparam int F  = 4;
    localparam int NP = 64;
    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic       start = 1'b0;
    logic [3:0] gap_cfg = '0;
    logic       grt = 1'b0;
    logic       fifo_ovch = 1'b0;
    logic [1:0] cred_ret = '0;
    logic       rd_en, busy, done, cred_err;
    logic [6:0] pkt_cnt;

    pe_inj_ctrl dut (
        .clk(clk), .rst_(rst_), .start(start), .gap_cfg(gap_cfg), .grt(grt),
        .fifo_ovch(fifo_ovch), .cred_ret(cred_ret), .rd_en(rd_en), .busy(busy),
        .done(done), .pkt_cnt(pkt_cnt), .cred_err(cred_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: credits as integers, progress as "flits sent in the
    // current packet" (0 = waiting for a head), remaining gap cycles, run flags.
    int m_cred[2];
    bit m_err, m_run, m_done, m_vc;
    int m_pkt, m_flit, m_gap;
    bit last_x, last_vc;

    function automatic bit m_rd();
        if (!m_run || m_gap > 0) return 1'b0;
        if (m_flit == 0) return (m_cred[0] > 0) && (m_cred[1] > 0);
        return m_cred[m_vc] > 0;
    endfunction

    task automatic m_reset();
        m_cred[0] = CD; m_cred[1] = CD;
        m_err = 0; m_run = 0; m_done = 0; m_vc = 0;
        m_pkt = 0; m_flit = 0; m_gap = 0;
        last_x = 0; last_vc = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("rd_en", rd_en, m_rd());
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("pkt_cnt", pkt_cnt, m_pkt);
        chk("cred_err", cred_err, m_err);
    endtask

    // Inputs are driven at the negedge; the model advances on the posedge and
    // the DUT is compared at the following negedge.
    task automatic step();
        bit x, vsel, d, r;
        @(posedge clk);
        x = m_rd() && grt;
        vsel = (m_flit == 0) ? fifo_ovch : m_vc;
        for (int v = 0; v < 2; v++) begin
            d = x && (vsel == v[0]);
            r = cred_ret[v];
            if (d && !r) m_cred[v]--;
            else if (r && !d) begin
                if (m_cred[v] == CD) m_err = 1;
                else m_cred[v]++;
            end
        end
        last_x = x; last_vc = vsel;
        if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_pkt = 0; m_flit = 0; m_gap = 0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (x) begin
            if (m_flit == 0) begin
                m_vc = fifo_ovch;
                m_flit = 1;
            end else begin
                m_flit++;
                if (m_flit == F) begin
                    m_flit = 0;
                    m_pkt++;
                    if (m_pkt == NP) begin
                        m_run = 0; m_done = 1;
                    end else begin
                        m_gap = gap_cfg;
                    end
                end
            end
        end
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_ = 1; start = 0; grt = 0; cred_ret = 0; gap_cfg = 0; fifo_ovch = 0;
        #2;
        m_reset();
        compare();
        @(negedge clk);
        rst_ = 0;
    endtask

    function automatic logic [1:0] ret_prev();
        if (!last_x) return 2'b00;
        return last_vc ? 2'b10 : 2'b01;
    endfunction

    initial begin
        int nx, lows, blow, n;
        #1;
        do_reset();
        chk("rst_rd_en", rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);

        // Test 1: full run, credits returned one cycle after use.
        grt = 1; gap_cfg = 0; start = 1;
        step();
        start = 0;
        nx = 0; lows = 0; n = 0;
        while (!done && n < 400) begin
            fifo_ovch = $urandom_range(0, 1);
            cred_ret = ret_prev();
            nx += (rd_en && grt) ? 1 : 0;
            lows += (busy && !rd_en) ? 1 : 0;
            step();
            n++;
        end
        chk("t1_xfers", nx, 256);
        chk("t1_done", done, 1);
        chk("t1_pkt_cnt", pkt_cnt, 64);
        chk("t1_rd_low", lows, 0);

        // Test 2: head on VC1 with no returns drains cred1, next head stalls.
        do_reset();
        grt = 1; fifo_ovch = 1; start = 1;
        step();
        start = 0;
        step();
        fifo_ovch = 0;
        repeat (3) step();
        chk("t2_stall", rd_en, 0);
        repeat (3) step();
        chk("t2_still_stalled", rd_en, 0);
        cred_ret = 2'b10;
        step();
        cred_ret = 0;
        chk("t2_resume", rd_en, 1);

        // Test 3: gap of 3 idle cycles; later gap_cfg changes must not matter.
        do_reset();
        grt = 1; gap_cfg = 3; start = 1;
        step();
        start = 0;
        lows = 0; blow = 0; n = 0;
        while (pkt_cnt != 2 && n < 100) begin
            cred_ret = ret_prev();
            fifo_ovch = $urandom_range(0, 1);
            if (pkt_cnt == 1 && !rd_en) begin
                lows++;
                gap_cfg = 9;
            end
            blow += busy ? 0 : 1;
            step();
            n++;
        end
        chk("t3_gap_len", lows, 3);
        chk("t3_busy_low", blow, 0);

        // Test 4: grant withheld mid-body.
        do_reset();
        grt = 1; start = 1;
        step();
        start = 0;
        repeat (2) step();
        grt = 0;
        repeat (5) step();
        chk("t4_hold_rd_en", rd_en, 1);
        chk("t4_hold_pkt", pkt_cnt, 0);
        grt = 1;
        repeat (2) step();
        chk("t4_pkt_done", pkt_cnt, 1);

        // Test 5: overflow return sets sticky error; use+return cancels.
        do_reset();
        cred_ret = 2'b01;
        step();
        cred_ret = 0;
        chk("t5_err", cred_err, 1);
        step();
        chk("t5_err_sticky", cred_err, 1);
        start = 1;
        step();
        start = 0; grt = 1; fifo_ovch = 0; cred_ret = 2'b01;
        step();
        cred_ret = 0;
        repeat (3) step();
        chk("t5_next_head", rd_en, 1);
        step();
        chk("t5_body_stall", rd_en, 0);

        // Test 6: async reset mid-body, then credits must be full again.
        do_reset();
        grt = 1; fifo_ovch = 0; start = 1;
        step();
        start = 0;
        repeat (2) step();
        #2;
        rst_ = 1;
        #1;
        chk("t6_async_rd_en", rd_en, 0);
        chk("t6_async_busy", busy, 0);
        do_reset();
        repeat (5) step();
        chk("t6_idle_rd_en", rd_en, 0);
        grt = 1; start = 1;
        step();
        start = 0;
        repeat (4) step();
        chk("t6_full_pkt", pkt_cnt, 1);

        // Random phase.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 19) == 0);
            grt = ($urandom_range(0, 3) != 0);
            fifo_ovch = $urandom_range(0, 1);
            cred_ret = ($urandom_range(0, 2) == 0) ? ret_prev() : 2'($urandom_range(0, 3) & $urandom_range(0, 3));
            gap_cfg = 4'($urandom_range(0, 3));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
